cmp_lgez_n_bit: RTL and testbench

Registered N-bit unsigned magnitude comparator with a zero/non-zero equality flag, encoded on two output bits. It compares operands x and y and reports less, greater, equal-and-zero, or equal-and-non-zero. It is used as an ALU flag source. The core is a tree of per-bit-pair compare cells that merge most-significant-first, followed by one output register stage.

---
 rtl/cmp_lgez_n_bit.sv | 85 ++++++++
 tb/tb_cmp_lgez_n_bit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cmp_lgez_n_bit.sv
// Purpose : registered unsigned compare of x vs y, code {rx,ry} = 00 eq-zero, 01 less, 10 greater, 11 eq-nonzero.
// Latency : 1 cycle (x/y sampled on rising clk, code visible until the next edge).
// Backpress: none; accepts one pair every cycle, no enable or handshake.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset, forces {rx,ry} to 00
//   x, y    p_WIDTH-bit unsigned operands
//   rx, ry  registered result code, rx is the MSB
module cmp_lgez_n_bit #(
    parameter int p_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [p_WIDTH-1:0] x,
    input  logic [p_WIDTH-1:0] y,
    output logic               rx,
    output logic               ry
);

    // Number of merge levels needed to reduce p_WIDTH cells to one.
    localparam int LEVELS = (p_WIDTH > 1) ? $clog2(p_WIDTH) : 0;

    // Node count at a given tree level (level 0 holds the per-bit cells).
    function automatic int level_count(input int lvl);
        return (p_WIDTH + (1 << lvl) - 1) >> lvl;
    endfunction

    // Combine a more-significant result h with a less-significant result l.
    // A decided (01/10) high part wins; otherwise the low part decides;
    // when both halves are equal the result is non-zero if either half is.
    function automatic logic [1:0] merge(input logic [1:0] h, input logic [1:0] l);
        logic [1:0] res;
        if (h == 2'b01 || h == 2'b10) begin
            res = h;
        end else if (l == 2'b01 || l == 2'b10) begin
            res = l;
        end else if (h == 2'b11 || l == 2'b11) begin
            res = 2'b11;
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

    logic [1:0] tree_code;

    // Balanced reduction tree. Within each level, higher index means higher
    // significance, so node j merges children 2j+1 (high) and 2j (low).
    // An odd leftover child is the most significant one and is passed up.
    genvar l, j;
    for (l = 0; l <= LEVELS; l++) begin : lvl_g
        localparam int N = level_count(l);
        logic [1:0] node [N];

        if (l == 0) begin : leaf_g
            // Per-bit cell: the code is simply {x[i], y[i]}.
            for (j = 0; j < N; j++) begin : cell_g
                assign node[j] = {x[j], y[j]};
            end
        end else begin : merge_g
            localparam int N_PREV = level_count(l - 1);
            for (j = 0; j < N; j++) begin : node_g
                if (2 * j + 1 < N_PREV) begin : pair_g
                    assign node[j] = merge(lvl_g[l-1].node[2*j+1], lvl_g[l-1].node[2*j]);
                end else begin : pass_g
                    assign node[j] = lvl_g[l-1].node[2*j];
                end
            end
        end
    end

    assign tree_code = lvl_g[LEVELS].node[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx <= 1'b0;
            ry <= 1'b0;
        end else begin
            rx <= tree_code[1];
            ry <= tree_code[0];
        end
    end

endmodule

// File: tb/tb_cmp_lgez_n_bit.sv
// Bench for cmp_lgez_n_bit at widths 1, 2, 3, 4 and 16 sharing one clock/reset.
// Inputs change on the falling edge; each result is checked on the next falling edge.
module tb_cmp_lgez_n_bit;

    logic        clk = 1'b0;
    logic        rst;

    logic [2:0]  x3, y3;
    logic        x1, y1;
    logic [1:0]  x2, y2;
    logic [3:0]  x4, y4;
    logic [15:0] x16, y16;

    logic rx3, ry3, rx1, ry1, rx2, ry2, rx4, ry4, rx16, ry16;

    logic [1:0] exp3, exp1, exp2, exp4, exp16;
    bit         pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmp_lgez_n_bit #(.p_WIDTH(3)) u_w3 (
        .clk(clk), .rst(rst), .x(x3), .y(y3), .rx(rx3), .ry(ry3)
    );
    cmp_lgez_n_bit #(.p_WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .x(x1), .y(y1), .rx(rx1), .ry(ry1)
    );
    cmp_lgez_n_bit #(.p_WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .x(x2), .y(y2), .rx(rx2), .ry(ry2)
    );
    cmp_lgez_n_bit #(.p_WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .x(x4), .y(y4), .rx(rx4), .ry(ry4)
    );
    cmp_lgez_n_bit #(.p_WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .x(x16), .y(y16), .rx(rx16), .ry(ry16)
    );

    // Reference: plain unsigned arithmetic comparison.
    function automatic logic [1:0] ref_code(input logic [15:0] a, input logic [15:0] b);
        if (a < b)  return 2'b01;
        if (a > b)  return 2'b10;
        if (a == 0) return 2'b00;
        return 2'b11;
    endfunction

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_w3"},  {rx3, ry3},   exp3);
        check({tag, "_w1"},  {rx1, ry1},   exp1);
        check({tag, "_w2"},  {rx2, ry2},   exp2);
        check({tag, "_w4"},  {rx4, ry4},   exp4);
        check({tag, "_w16"}, {rx16, ry16}, exp16);
    endtask

    // One cycle: check the pair applied last cycle, then apply a new pair.
    task automatic step(input string tag,
                        input logic [2:0] a3, input logic [2:0] b3,
                        input logic a1, input logic b1,
                        input logic [1:0] a2, input logic [1:0] b2,
                        input logic [3:0] a4, input logic [3:0] b4,
                        input logic [15:0] a16, input logic [15:0] b16);
        @(negedge clk);
        if (pend) check_all(tag);
        x3 = a3;   y3 = b3;   exp3  = ref_code({13'd0, a3}, {13'd0, b3});
        x1 = a1;   y1 = b1;   exp1  = ref_code({15'd0, a1}, {15'd0, b1});
        x2 = a2;   y2 = b2;   exp2  = ref_code({14'd0, a2}, {14'd0, b2});
        x4 = a4;   y4 = b4;   exp4  = ref_code({12'd0, a4}, {12'd0, b4});
        x16 = a16; y16 = b16; exp16 = ref_code(a16, b16);
        pend = 1'b1;
    endtask

    // Directed width-3 and width-16 pair; the small widths get random values.
    task automatic step3(input string tag, input logic [2:0] a3, input logic [2:0] b3,
                         input logic [15:0] a16, input logic [15:0] b16);
        logic [31:0] r;
        r = $urandom;
        step(tag, a3, b3, r[0], r[1], r[3:2], r[5:4], r[9:6], r[13:10], a16, b16);
    endtask

    // Consume the outstanding expectation without applying new inputs.
    task automatic flush(input string tag);
        @(negedge clk);
        if (pend) check_all(tag);
        pend = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] b16;
        pend = 1'b0;
        rst  = 1'b1;
        x3 = 3'b101; y3 = 3'b010;
        x1 = 1'b1;   y1 = 1'b0;
        x2 = 2'b11;  y2 = 2'b01;
        x4 = 4'hA;   y4 = 4'h3;
        x16 = 16'h8000; y16 = 16'h0001;
        exp3 = 2'b00; exp1 = 2'b00; exp2 = 2'b00; exp4 = 2'b00; exp16 = 2'b00;

        // Reset held across clock edges keeps every output at 00.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all("rst_hold");
        end

        // Release just after a rising edge; the next edge loads these inputs.
        @(posedge clk);
        #1 rst = 1'b0;
        step3("first", 3'b100, 3'b001, 16'h8000, 16'h7FFF);

        // MSB dominance and equality codes.
        step3("msb_gt", 3'b100, 3'b011, 16'h0001, 16'h0001);
        step3("msb_lt", 3'b011, 3'b100, 16'h0000, 16'h0000);
        step3("eq_z",   3'b000, 3'b000, 16'hFFFF, 16'hFFFE);
        step3("eq_1",   3'b001, 3'b001, 16'h7FFF, 16'h8000);
        step3("eq_7",   3'b111, 3'b111, 16'hFFFF, 16'hFFFF);

        // Back-to-back pipelining: 01, 10, 00, 11 with no bubbles.
        step3("pipe_a", 3'd1, 3'd2, 16'd1, 16'd2);
        step3("pipe_b", 3'd2, 3'd1, 16'd2, 16'd1);
        step3("pipe_c", 3'd0, 3'd0, 16'd0, 16'd0);
        step3("pipe_d", 3'd5, 3'd5, 16'd5, 16'd5);

        // Asynchronous reset mid-cycle after a GREATER result.
        step3("pre_arst", 3'b110, 3'b010, 16'h1234, 16'h0034);
        flush("pre_arst");
        #2 rst = 1'b1;
        #1 check("arst_drop_w3",  {rx3, ry3},   2'b00);
        check("arst_drop_w16", {rx16, ry16}, 2'b00);
        @(posedge clk);
        #1 check("arst_hold_w3", {rx3, ry3}, 2'b00);
        rst = 1'b0;

        // Exhaustive sweeps: w4 covers all 256 pairs, w3 all 64, w2 all 16,
        // w1 all 4 (via the low bits of i); w16 random with frequent equality.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = i[7:0];
            r = $urandom;
            b16 = (iv[2:0] == 3'd0) ? r[15:0] : r[31:16];
            step("sweep", iv[5:3], iv[2:0], iv[1], iv[0], iv[3:2], iv[1:0],
                 iv[7:4], iv[3:0], r[15:0], b16);
        end
        flush("sweep_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
